output_collector: RTL and testbench

OUTPUT_COLLECTOR -- requirements
Module: output_collector

---
 rtl/output_collector.sv | 162 ++++++++++++++++
 tb/tb_output_collector.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_collector.sv
// -----------------------------------------------------------------------------
// output_collector
//   Collects one frame of 32-bit result words from the upstream datapath into a
//   first-word-fall-through FIFO. The host drains the FIFO through a
//   valid/ready pop port. The frame length is announced up front on out_count.
//   The block tracks received words until the frame is complete. It then waits
//   for the FIFO to drain and raises done.
//
// Ports
//   clk             : clock, all state changes on the rising edge
//   clear           : asynchronous active-low reset
//   enable          : gates capture of y_valid words (pops are unaffected)
//   data_in         : result word, valid when y_valid=1
//   y_valid         : data_in valid this cycle
//   out_count       : expected word count of the next frame
//   out_count_valid : out_count valid this cycle
//   rd_data         : FIFO head word (0 while empty)
//   rd_valid        : FIFO not empty
//   rd_ready        : host pop request, effective when rd_valid=1
//   level           : FIFO occupancy, 0..DEPTH
//   done            : frame fully received and FIFO drained
//   overflow        : a word was dropped on full during this frame
//   protocol_err    : a word or count arrived in an illegal state (sticky)
// -----------------------------------------------------------------------------
module output_collector #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          enable,
    input  logic [31:0]   data_in,
    input  logic          y_valid,
    input  logic [31:0]   out_count,
    input  logic          out_count_valid,
    output logic [31:0]   rd_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [AW:0]   level,
    output logic          done,
    output logic          overflow,
    output logic          protocol_err
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_DRAIN   = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

    logic [31:0]   r_mem [0:DEPTH-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_level;
    logic [1:0]    r_state;
    logic [31:0]   r_expected;
    logic [31:0]   r_received;
    logic          r_overflow;
    logic          r_protocol_err;

    logic          w_word;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_push;
    logic [31:0]   w_recv_next;

    assign w_word      = y_valid & enable;
    assign w_full      = (r_level == FULL_LEVEL);
    assign w_empty     = (r_level == '0);
    // Pop is only possible on a non-empty FIFO, so an empty FIFO never bypasses.
    assign w_pop       = rd_ready & ~w_empty;
    // A full FIFO still accepts the push when the head leaves in the same cycle.
    assign w_push      = (r_state == S_COLLECT) & w_word & (~w_full | w_pop);
    assign w_recv_next = r_received + 32'd1;

    // Storage is data-only and needs no reset; rd_data is masked while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            r_state        <= S_IDLE;
            r_expected     <= '0;
            r_received     <= '0;
            r_overflow     <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (out_count_valid) begin
                        r_expected <= out_count;
                        r_received <= '0;
                        r_overflow <= 1'b0;
                        // An empty frame completes immediately.
                        r_state    <= (out_count == '0) ? S_DONE : S_COLLECT;
                    end
                    if (w_word) begin
                        r_protocol_err <= 1'b1;
                    end
                end
                S_COLLECT: begin
                    if (w_word) begin
                        // Dropped words are still counted so the frame ends on time.
                        r_received <= w_recv_next;
                        if (w_full && !w_pop) begin
                            r_overflow <= 1'b1;
                        end
                        if (w_recv_next == r_expected) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    if (out_count_valid) begin
                        r_protocol_err <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                    end
                    if (w_word || out_count_valid) begin
                        r_protocol_err <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_valid     = ~w_empty;
    assign rd_data      = w_empty ? 32'd0 : r_mem[r_rd_ptr];
    assign level        = r_level;
    assign done         = (r_state == S_DONE);
    assign overflow     = r_overflow;
    assign protocol_err = r_protocol_err;

endmodule

// File: tb/tb_output_collector.sv
module tb_output_collector;

    logic        clk = 1'b0;
    logic        clear;
    logic        enable;
    logic [31:0] data_in;
    logic        y_valid;
    logic [31:0] out_count;
    logic        out_count_valid;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [4:0]  level;
    logic        done;
    logic        overflow;
    logic        protocol_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    output_collector #(.DEPTH(16), .AW(4)) dut (
        .clk             (clk),
        .clear           (clear),
        .enable          (enable),
        .data_in         (data_in),
        .y_valid         (y_valid),
        .out_count       (out_count),
        .out_count_valid (out_count_valid),
        .rd_data         (rd_data),
        .rd_valid        (rd_valid),
        .rd_ready        (rd_ready),
        .level           (level),
        .done            (done),
        .overflow        (overflow),
        .protocol_err    (protocol_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear = 1'b0;
        step();
        clear = 1'b1;
        step();
    endtask

    task automatic start_frame(input logic [31:0] cnt);
        out_count       = cnt;
        out_count_valid = 1'b1;
        step();
        out_count_valid = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL rst_level: got %0d expected 0", level); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b expected 0", rd_valid); end
        n_checks++; if (rd_data !== 32'd0) begin n_fail++; $display("FAIL rst_rd_data: got %h expected 0", rd_data); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL rst_perr: got %b expected 0", protocol_err); end
        step();
        step();
        clear = 1'b1;
        step();
    endtask

    task automatic test_zero_count();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_idle_done: got %b expected 0", done); end
        start_frame(32'd0);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", done); end
        data_in = 32'hDEAD; y_valid = 1'b1;
        step();
        y_valid = 1'b0;
        n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL zero_perr: got %b expected 1", protocol_err); end
        n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL zero_level: got %0d expected 0", level); end
        do_reset();
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL zero_perr_clr: got %b expected 0", protocol_err); end
    endtask

    task automatic test_basic_frame();
        start_frame(32'd3);
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done0: got %b expected 0", done); end
        rd_ready = 1'b1;
        data_in = 32'hA; y_valid = 1'b1; step();
        n_checks++; if (rd_data !== 32'hA || rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_rdA: got %h/%b expected a/1", rd_data, rd_valid); end
        data_in = 32'hB; step();
        n_checks++; if (rd_data !== 32'hB || level !== 5'd1) begin n_fail++; $display("FAIL basic_rdB: got %h lvl %0d expected b lvl 1", rd_data, level); end
        data_in = 32'hC; step();
        n_checks++; if (rd_data !== 32'hC) begin n_fail++; $display("FAIL basic_rdC: got %h expected c", rd_data); end
        y_valid = 1'b0; step();
        n_checks++; if (level !== 5'd0 || done !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got lvl %0d done %b expected 0/0", level, done); end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL basic_ovf: got %b expected 0", overflow); end
        rd_ready = 1'b0;
    endtask

    task automatic test_overflow();
        start_frame(32'd20);
        rd_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            data_in = 32'h100 + 32'(i); y_valid = 1'b1; step();
        end
        y_valid = 1'b0;
        n_checks++; if (level !== 5'd16) begin n_fail++; $display("FAIL ovf_level: got %0d expected 16", level); end
        n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ovf_done0: got %b expected 0", done); end
        n_checks++; if (protocol_err !== 1'b0) begin n_fail++; $display("FAIL ovf_perr: got %b expected 0", protocol_err); end
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_checks++; if (rd_data !== 32'h100 + 32'(i)) begin n_fail++; $display("FAIL ovf_pop%0d: got %h expected %h", i, rd_data, 32'h100 + 32'(i)); end
            step();
        end
        n_checks++; if (level !== 5'd0 || done !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got lvl %0d done %b expected 0/0", level, done); end
        step();
        n_checks++; if (done !== 1'b1 || overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_done: got done %b ovf %b expected 1/1", done, overflow); end
        rd_ready = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_word;
        start_frame(32'd20);
        n_checks++; if (overflow !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL fpp_start: got ovf %b done %b expected 0/0", overflow, done); end
        rd_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            data_in = 32'h200 + 32'(i); y_valid = 1'b1; step();
        end
        n_checks++; if (level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_full: got lvl %0d ovf %b expected 16/0", level, overflow); end
        data_in = 32'h210; rd_ready = 1'b1; step();
        rd_ready = 1'b0;
        n_checks++; if (level !== 5'd16 || overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_pushpop: got lvl %0d ovf %b expected 16/0", level, overflow); end
        n_checks++; if (rd_data !== 32'h201) begin n_fail++; $display("FAIL fpp_head: got %h expected 201", rd_data); end
        data_in = 32'h211; step();
        n_checks++; if (level !== 5'd16 || overflow !== 1'b1) begin n_fail++; $display("FAIL fpp_drop: got lvl %0d ovf %b expected 16/1", level, overflow); end
        data_in = 32'h212; step();
        data_in = 32'h213; step();
        y_valid = 1'b0;
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_word = (i < 15) ? 32'h201 + 32'(i) : 32'h210;
            n_checks++; if (rd_data !== exp_word) begin n_fail++; $display("FAIL fpp_pop%0d: got %h expected %h", i, rd_data, exp_word); end
            step();
        end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL fpp_done: got %b expected 1", done); end
        rd_ready = 1'b0;
    endtask

    task automatic test_enable_gate();
        start_frame(32'd3);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data_in = 32'h500 + 32'(i); y_valid = 1'b1; step();
        end
        y_valid = 1'b0; enable = 1'b1;
        n_checks++; if (level !== 5'd0 || rd_valid !== 1'b0) begin n_fail++; $display("FAIL en_level: got lvl %0d vld %b expected 0/0", level, rd_valid); end
        n_checks++; if (protocol_err !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL en_flags: got perr %b ovf %b expected 0/0", protocol_err, overflow); end
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            data_in = 32'h600 + 32'(i); y_valid = 1'b1; step();
        end
        y_valid = 1'b0;
        n_checks++; if (level !== 5'd3 || rd_data !== 32'h600) begin n_fail++; $display("FAIL en_fill: got lvl %0d head %h expected 3/600", level, rd_data); end
        rd_ready = 1'b1;
        step();
        n_checks++; if (rd_data !== 32'h601) begin n_fail++; $display("FAIL en_pop1: got %h expected 601", rd_data); end
        step();
        n_checks++; if (rd_data !== 32'h602) begin n_fail++; $display("FAIL en_pop2: got %h expected 602", rd_data); end
        step();
        n_checks++; if (level !== 5'd0 || done !== 1'b0) begin n_fail++; $display("FAIL en_empty: got lvl %0d done %b expected 0/0", level, done); end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL en_done: got %b expected 1", done); end
        rd_ready = 1'b0;
    endtask

    task automatic test_count_in_collect();
        start_frame(32'd2);
        out_count = 32'd7; out_count_valid = 1'b1; step();
        out_count_valid = 1'b0;
        n_checks++; if (protocol_err !== 1'b1) begin n_fail++; $display("FAIL cnt_perr: got %b expected 1", protocol_err); end
        rd_ready = 1'b1;
        data_in = 32'h700; y_valid = 1'b1; step();
        data_in = 32'h701; step();
        y_valid = 1'b0;
        step();
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL cnt_ignored: got done %b expected 1", done); end
        rd_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        start_frame(32'd10);
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            data_in = 32'h300 + 32'(i); y_valid = 1'b1; step();
        end
        y_valid = 1'b0;
        n_checks++; if (level !== 5'd5 || protocol_err !== 1'b1) begin n_fail++; $display("FAIL ar_pre: got lvl %0d perr %b expected 5/1", level, protocol_err); end
        #3;
        clear = 1'b0;
        #1;
        n_checks++; if (level !== 5'd0 || rd_valid !== 1'b0 || rd_data !== 32'd0) begin n_fail++; $display("FAIL ar_fifo: got lvl %0d vld %b data %h expected 0/0/0", level, rd_valid, rd_data); end
        n_checks++; if (done !== 1'b0 || overflow !== 1'b0 || protocol_err !== 1'b0) begin n_fail++; $display("FAIL ar_flags: got done %b ovf %b perr %b expected 0/0/0", done, overflow, protocol_err); end
        clear = 1'b1;
        step();
        start_frame(32'd2);
        rd_ready = 1'b1;
        data_in = 32'h400; y_valid = 1'b1; step();
        n_checks++; if (rd_data !== 32'h400 || level !== 5'd1) begin n_fail++; $display("FAIL ar_new0: got %h lvl %0d expected 400/1", rd_data, level); end
        data_in = 32'h401; step();
        n_checks++; if (rd_data !== 32'h401) begin n_fail++; $display("FAIL ar_new1: got %h expected 401", rd_data); end
        y_valid = 1'b0;
        step();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL ar_drain: got %b expected 0", done); end
        step();
        n_checks++; if (done !== 1'b1 || protocol_err !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL ar_done: got done %b perr %b ovf %b expected 1/0/0", done, protocol_err, overflow); end
        rd_ready = 1'b0;
    endtask

    initial begin
        clear           = 1'b0;
        enable          = 1'b1;
        data_in         = '0;
        y_valid         = 1'b0;
        out_count       = '0;
        out_count_valid = 1'b0;
        rd_ready        = 1'b0;

        test_reset();
        test_zero_count();
        test_basic_frame();
        test_overflow();
        test_full_push_pop();
        test_enable_gate();
        test_count_in_collect();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
